// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Bundles the two requester byte streams, the UART TX FIFO write port and the
//   arbiter status outputs.
//   slave  : arbiter side (consumes requests, drives readys/FIFO write/status)
//   master : requester/FIFO side (drives requests and fifoFull)
//   req0*/req1*      valid/data/last in, ready out (per requester)
//   fifoFull         in  : UART TX FIFO full
//   fifoWriteRequest out : FIFO wrreq
//   fifoInData       out : FIFO data (0 when not writing)
//   grantOwner       out : 00 none, 01 port 0, 10 port 1
//   abortPulse       out : one-cycle pulse on timeout release
interface uart_tx_arbiter_if #(
  parameter int DataWidth = 8
);
  logic                 req0Valid;
  logic [DataWidth-1:0] req0Data;
  logic                 req0Last;
  logic                 req0Ready;
  logic                 req1Valid;
  logic [DataWidth-1:0] req1Data;
  logic                 req1Last;
  logic                 req1Ready;
  logic                 fifoFull;
  logic                 fifoWriteRequest;
  logic [DataWidth-1:0] fifoInData;
  logic [1:0]           grantOwner;
  logic                 abortPulse;

  modport slave (
    input  req0Valid, req0Data, req0Last, req1Valid, req1Data, req1Last, fifoFull,
    output req0Ready, req1Ready, fifoWriteRequest, fifoInData, grantOwner, abortPulse
  );

  modport master (
    output req0Valid, req0Data, req0Last, req1Valid, req1Data, req1Last, fifoFull,
    input  req0Ready, req1Ready, fifoWriteRequest, fifoInData, grantOwner, abortPulse
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares the UART TX FIFO write port between two byte-stream requesters with
//   packet-atomic round-robin arbitration and a mid-packet stall timeout.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : uart_tx_arbiter_if.slave (requests, FIFO write port, status)
//
//   state  | meaning
//   IDLE   | no owner; picks the next packet owner (1-cycle arbitration)
//   GRANT0 | port 0 owns the FIFO until its last byte or a timeout
//   GRANT1 | port 1 owns the FIFO until its last byte or a timeout
module uart_tx_arbiter #(
  parameter int DataWidth     = 8,
  parameter int TimeoutCycles = 1024
) (
  input logic                clk,
  input logic                rst,
  uart_tx_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam bit TimerEn = (TimeoutCycles > 0);
  localparam int TimerW  = TimerEn ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TimerEn ? TimeoutCycles - 1 : 0);

  state_t            state_q, state_d;
  logic              rr_last_q, rr_last_d;  // 0: port 0 served last, 1: port 1
  logic [TimerW-1:0] timer_q, timer_d;
  logic              abort_q, abort_d;

  logic                 sel_valid;
  logic [DataWidth-1:0] sel_data;
  logic                 sel_last;
  logic                 xfer;

  // Only the granted port is looked at; the other port's inputs are ignored.
  assign sel_valid = (state_q == GRANT1) ? bus.req1Valid : bus.req0Valid;
  assign sel_data  = (state_q == GRANT1) ? bus.req1Data  : bus.req0Data;
  assign sel_last  = (state_q == GRANT1) ? bus.req1Last  : bus.req0Last;
  assign xfer      = (state_q != IDLE) && sel_valid && !bus.fifoFull;

  assign bus.req0Ready        = (state_q == GRANT0) && !bus.fifoFull;
  assign bus.req1Ready        = (state_q == GRANT1) && !bus.fifoFull;
  assign bus.fifoWriteRequest = xfer;
  assign bus.fifoInData       = xfer ? sel_data : '0;
  assign bus.grantOwner       = {state_q == GRANT1, state_q == GRANT0};
  assign bus.abortPulse       = abort_q;

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    timer_d   = timer_q;
    abort_d   = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        // Port 0 wins when alone, or when both wait and port 1 was served last.
        if (bus.req0Valid && (!bus.req1Valid || rr_last_q)) begin
          state_d = GRANT0;
        end else if (bus.req1Valid) begin
          state_d = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (xfer) begin
          timer_d = '0;
          if (sel_last) begin
            state_d   = IDLE;
            rr_last_d = (state_q == GRANT1);
          end
        end else if (TimerEn && !sel_valid && !bus.fifoFull) begin
          // FIFO backpressure is not a requester stall, so the timer only
          // advances when the owner has nothing to offer.
          if (timer_q == TimerMax) begin
            state_d   = IDLE;
            rr_last_d = (state_q == GRANT1);
            abort_d   = 1'b1;
            timer_d   = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      timer_q   <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      timer_q   <= timer_d;
      abort_q   <= abort_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter. Expected FIFO writes (owner, byte) are
//   queued as stimulus is issued; a monitor pops and compares on every write.
module tb_uart_tx_arbiter;

  localparam int Dw      = 8;
  localparam int Tmo     = 16;
  localparam int Budget  = 200;

  typedef struct packed {
    logic [1:0] owner;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  logic [8:0] qa[$];
  logic [8:0] qb[$];

  uart_tx_arbiter_if #(.DataWidth(Dw)) bus ();

  uart_tx_arbiter #(.DataWidth(Dw), .TimeoutCycles(Tmo)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push(input logic [1:0] o, input logic [7:0] d);
    exp_t e;
    e.owner = o;
    e.data  = d;
    exp_q.push_back(e);
  endfunction

  task automatic drive(input int p, input logic v, input logic [7:0] d, input logic l);
    if (p == 0) begin
      bus.req0Valid = v; bus.req0Data = d; bus.req0Last = l;
    end else begin
      bus.req1Valid = v; bus.req1Data = d; bus.req1Last = l;
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? bus.req0Ready : bus.req1Ready;
  endfunction

  // Each entry is {last, data}; valid stays high between bytes.
  task automatic send_seq(input int p, input logic [8:0] seq[$]);
    int n;
    foreach (seq[i]) begin
      drive(p, 1'b1, seq[i][7:0], seq[i][8]);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rdy(p) && n < Budget);
      if (!rdy(p)) check($sformatf("handshake_timeout_p%0d", p), 0, 1);
      @(posedge clk); #1;
    end
    drive(p, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    bus.fifoFull = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.fifoWriteRequest) begin
        check("wr_while_full", bus.fifoFull, 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got %0h/%0h expected none at %0t",
                   bus.grantOwner, bus.fifoInData, $time);
        end else begin
          e = exp_q.pop_front();
          check("wr_owner", bus.grantOwner, e.owner);
          check("wr_data", bus.fifoInData, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int k;
    int bad;
    do_reset();

    // Reset state
    @(negedge clk);
    check("reset_outputs", {bus.grantOwner, bus.req0Ready, bus.req1Ready, bus.fifoWriteRequest,
                            bus.fifoInData, bus.abortPulse}, 0);
    @(posedge clk); #1;

    // 1: single requester, 3-byte packet
    push(2'b01, 8'h1B); push(2'b01, 8'h5B); push(2'b01, 8'h41);
    qa = '{9'h01B, 9'h05B, 9'h141};
    fork
      send_seq(0, qa);
      begin
        @(negedge clk);
        check("t1_arb_latency_grant", bus.grantOwner, 2'b00);
        @(negedge clk);
        check("t1_grant0", bus.grantOwner, 2'b01);
        check("t1_first_write", bus.fifoWriteRequest, 1);
      end
    join
    @(negedge clk);
    check("t1_back_to_idle", bus.grantOwner, 2'b00);

    // 2: both valid from reset, packets never interleave
    do_reset();
    push(2'b01, 8'h1B); push(2'b01, 8'h5B); push(2'b01, 8'h43);
    push(2'b10, 8'h1B); push(2'b10, 8'h5B); push(2'b10, 8'h30); push(2'b10, 8'h6E);
    qa = '{9'h01B, 9'h05B, 9'h143};
    qb = '{9'h01B, 9'h05B, 9'h030, 9'h16E};
    fork
      send_seq(0, qa);
      send_seq(1, qb);
    join

    // 3: FIFO full for 50 cycles mid-packet; no ready, no write, no abort
    push(2'b01, 8'hA0); push(2'b01, 8'hA1); push(2'b01, 8'hA2);
    qa = '{9'h0A0, 9'h0A1, 9'h1A2};
    fork
      send_seq(0, qa);
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!bus.fifoWriteRequest && n < Budget);
        check("t3_first_write_seen", bus.fifoWriteRequest, 1);
        @(posedge clk); #1 bus.fifoFull = 1'b1;
        bad = 0;
        repeat (50) begin
          @(negedge clk);
          if (bus.req0Ready || bus.fifoWriteRequest || bus.abortPulse) bad++;
        end
        check("t3_stall_quiet_cycles", bad, 0);
        check("t3_grant_held", bus.grantOwner, 2'b01);
        @(posedge clk); #1 bus.fifoFull = 1'b0;
      end
    join

    // 4: port 1 stalls mid-packet; timeout releases it, port 0 goes next
    push(2'b10, 8'h55); push(2'b01, 8'h77);
    qb = '{9'h055};
    qa = '{9'h177};
    fork
      send_seq(1, qb);
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!(bus.fifoWriteRequest && bus.grantOwner == 2'b10) && n < Budget);
        check("t4_port1_write_seen", bus.fifoWriteRequest, 1);
        fork
          send_seq(0, qa);
          begin
            // Transfer clocks in at edge 0; the pulse register rises at edge
            // Tmo, so it is first seen Tmo+1 negedges after the transfer.
            k = 0;
            do begin
              @(negedge clk);
              k++;
            end while (!bus.abortPulse && k < 40);
            check("t4_abort_latency", k, Tmo + 1);
            check("t4_idle_at_abort", bus.grantOwner, 2'b00);
            @(negedge clk);
            check("t4_abort_one_cycle", bus.abortPulse, 0);
            check("t4_port0_next", bus.grantOwner, 2'b01);
          end
        join
      end
    join
    push(2'b10, 8'h56);
    qb = '{9'h156};
    send_seq(1, qb);

    // 5: continuous single-byte packets from both ports alternate
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(2'b01, 8'hB0 + 8'(i));
      push(2'b10, 8'hC0 + 8'(i));
    end
    qa = '{9'h1B0, 9'h1B1, 9'h1B2, 9'h1B3};
    qb = '{9'h1C0, 9'h1C1, 9'h1C2, 9'h1C3};
    fork
      send_seq(0, qa);
      send_seq(1, qb);
    join

    // 6: reset mid-packet; outputs drop at once, port 0 has priority after
    push(2'b01, 8'h10);
    qa = '{9'h110};
    send_seq(0, qa);
    push(2'b10, 8'h31);
    drive(1, 1'b1, 8'h31, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.fifoWriteRequest && n < Budget);
    check("t6_first_byte_seen", bus.fifoWriteRequest, 1);
    @(posedge clk); #1;
    drive(1, 1'b1, 8'h32, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("t6_outputs_in_reset", {bus.grantOwner, bus.req0Ready, bus.req1Ready,
                                  bus.fifoWriteRequest, bus.fifoInData, bus.abortPulse}, 0);
    drive(1, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    push(2'b01, 8'h99); push(2'b10, 8'h32);
    qa = '{9'h199};
    qb = '{9'h132};
    fork
      send_seq(0, qa);
      send_seq(1, qb);
      begin
        @(negedge clk);
        check("t6_idle_after_reset", bus.grantOwner, 2'b00);
      end
    join

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
